// File: rtl/noc_arb_pkg.sv
// Shared helpers for NoC switch arbiters: width derivation, defaults and one-hot encoding.
package noc_arb_pkg;

  localparam int unsigned DefaultWeightW = 3;
  localparam int unsigned MaxReqs        = 32;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int unsigned id_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // OR-reduction encoder; only meaningful for one-hot or all-zero inputs.
  function automatic int unsigned onehot_to_idx(input logic [MaxReqs-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MaxReqs; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/matrix_prio_core.sv
// IN_N x IN_N least-recently-served priority matrix; prio_q[i][j] = 1 means i beats j.
module matrix_prio_core
  import noc_arb_pkg::*;
#(
  parameter int unsigned IN_N = 5,
  parameter int unsigned ID_W = id_width(IN_N)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [IN_N-1:0] req_i,
  input  logic            upd_i,
  input  logic [ID_W-1:0] upd_id_i,
  output logic [IN_N-1:0] winner_o
);

  logic [IN_N-1:0][IN_N-1:0] prio_q, prio_d;
  logic [IN_N-1:0]           blocked;

  always_comb begin
    blocked  = '0;
    winner_o = '0;
    for (int i = 0; i < IN_N; i++) begin
      for (int j = 0; j < IN_N; j++) begin
        if (j != i && req_i[j] && prio_q[j][i]) blocked[i] = 1'b1;
      end
      winner_o[i] = req_i[i] & ~blocked[i];
    end
  end

  // Served id drops below everyone: clear its row, set its column.
  always_comb begin
    prio_d = prio_q;
    if (upd_i) begin
      for (int i = 0; i < IN_N; i++) begin
        for (int j = 0; j < IN_N; j++) begin
          if (ID_W'(i) == upd_id_i) begin
            prio_d[i][j] = 1'b0;
          end else if (ID_W'(j) == upd_id_i) begin
            prio_d[i][j] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < IN_N; i++) begin
        for (int j = 0; j < IN_N; j++) begin
          prio_q[i][j] <= (j > i);
        end
      end
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/wormhole_matrix_arbiter.sv
// Packet-locking weighted matrix arbiter for one NoC switch output port.
module wormhole_matrix_arbiter
  import noc_arb_pkg::*;
#(
  parameter int unsigned IN_N     = 5,
  parameter int unsigned WEIGHT_W = DefaultWeightW,
  parameter int unsigned ID_W     = id_width(IN_N)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [IN_N-1:0]          req_i,
  input  logic [IN_N-1:0]          last_i,
  input  logic                     ack_i,
  input  logic [IN_N*WEIGHT_W-1:0] weight_i,
  output logic [IN_N-1:0]          grant_o,
  output logic [ID_W-1:0]          grant_id_o,
  output logic                     grant_valid_o,
  output logic                     locked_o
);

  logic                lock_q, lock_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [WEIGHT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]     cnt_id_q, cnt_id_d;

  logic [IN_N-1:0]     winner;
  logic [IN_N-1:0]     grant;
  logic [ID_W-1:0]     gid;
  logic                gvalid;
  logic                done;
  logic                upd;
  logic [WEIGHT_W-1:0] cnt_base;
  logic [WEIGHT_W-1:0] weight_sel;
  logic [WEIGHT_W:0]   cnt_inc;
  logic [WEIGHT_W:0]   weight_eff;

  matrix_prio_core #(
    .IN_N (IN_N),
    .ID_W (ID_W)
  ) u_prio (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .upd_i    (upd),
    .upd_id_i (gid),
    .winner_o (winner)
  );

  // Outputs are forced low during reset even though arbitration is combinational.
  always_comb begin
    grant = '0;
    if (!rst_ni) begin
      grant = '0;
    end else if (lock_q) begin
      grant = req_i & (IN_N'(1) << owner_q);
    end else begin
      grant = winner;
    end
  end

  assign gid    = ID_W'(onehot_to_idx(MaxReqs'(grant)));
  assign gvalid = |grant;
  assign done   = gvalid & ack_i & last_i[gid];

  always_comb begin
    cnt_id_d = cnt_id_q;
    cnt_base = cnt_q;
    // A fresh winner restarts its burst before this cycle's completion counts.
    if (!lock_q && gvalid && (gid != cnt_id_q)) begin
      cnt_id_d = gid;
      cnt_base = '0;
    end
    weight_sel = weight_i[32'(gid) * WEIGHT_W +: WEIGHT_W];
    weight_eff = (weight_sel == '0) ? (WEIGHT_W + 1)'(1) : {1'b0, weight_sel};
    cnt_inc    = {1'b0, cnt_base} + (WEIGHT_W + 1)'(1);
    cnt_d      = cnt_base;
    upd        = 1'b0;
    if (done) begin
      if (cnt_inc >= weight_eff) begin
        upd   = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_inc[WEIGHT_W-1:0];
      end
    end
  end

  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    if (!lock_q) begin
      if (gvalid && !done) begin
        lock_d  = 1'b1;
        owner_d = gid;
      end
    end else if (done) begin
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q   <= 1'b0;
      owner_q  <= '0;
      cnt_q    <= '0;
      cnt_id_q <= '0;
    end else begin
      lock_q   <= lock_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      cnt_id_q <= cnt_id_d;
    end
  end

  assign grant_o       = grant;
  assign grant_id_o    = gid;
  assign grant_valid_o = gvalid;
  assign locked_o      = lock_q;

endmodule

// File: tb/tb_wormhole_matrix_arbiter.sv
// Scoreboard bench: a priority-list reference model predicts each cycle's grant and lock.
module tb_wormhole_matrix_arbiter;

  localparam int N  = 5;
  localparam int WW = 3;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  last = '0;
  logic          ack = 1'b0;
  logic [N*WW-1:0] weight = '0;
  logic [N-1:0]  grant;
  logic [IW-1:0] grant_id;
  logic          grant_valid;
  logic          locked;

  wormhole_matrix_arbiter #(
    .IN_N     (N),
    .WEIGHT_W (WW),
    .ID_W     (IW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_i         (req),
    .last_i        (last),
    .ack_i         (ack),
    .weight_i      (weight),
    .grant_o       (grant),
    .grant_id_o    (grant_id),
    .grant_valid_o (grant_valid),
    .locked_o      (locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  grant;
    logic [IW-1:0] gid;
    logic          valid;
    logic          locked;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: priority as an ordered list, head = highest priority.
  int order[$];
  bit m_lock;
  int m_owner;
  int m_cnt;
  int m_cnt_id;
  int rem[N];

  function automatic void model_reset();
    order = {};
    for (int i = 0; i < N; i++) order.push_back(i);
    m_lock   = 1'b0;
    m_owner  = 0;
    m_cnt    = 0;
    m_cnt_id = 0;
  endfunction

  function automatic int wfield(input int k);
    logic [WW-1:0] f;
    f = weight[k*WW +: WW];
    return int'(f);
  endfunction

  task automatic model_cycle(output int g);
    exp_t e;
    bit   done;
    int   w;
    g = -1;
    if (m_lock) begin
      if (req[m_owner]) g = m_owner;
    end else begin
      foreach (order[k]) if (g < 0 && req[order[k]]) g = order[k];
    end
    e = '0;
    if (g >= 0) begin
      e.grant[g] = 1'b1;
      e.gid      = IW'(g);
      e.valid    = 1'b1;
    end
    e.locked = m_lock;
    exp_q.push_back(e);
    done = (g >= 0) && ack && last[g];
    if (!m_lock && g >= 0 && g != m_cnt_id) begin
      m_cnt_id = g;
      m_cnt    = 0;
    end
    if (done) begin
      w = wfield(g);
      if (w == 0) w = 1;
      if (m_cnt + 1 >= w) begin
        foreach (order[k]) if (order[k] == g) begin
          order.delete(k);
          break;
        end
        order.push_back(g);
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    if (!m_lock) begin
      if (g >= 0 && !done) begin
        m_lock  = 1'b1;
        m_owner = g;
      end
    end else if (done) begin
      m_lock = 1'b0;
    end
  endtask

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic a);
    int g;
    @(posedge clk);
    #1;
    req  = r;
    last = l;
    ack  = a;
    model_cycle(g);
  endtask

  // Reset is held for one cycle with the given requests to show outputs stay low.
  task automatic do_reset(input logic [N-1:0] r);
    @(posedge clk);
    #1;
    rst_ni = 1'b0;
    req    = r;
    last   = '0;
    ack    = 1'b1;
    model_reset();
    exp_q.push_back('0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    req    = '0;
    ack    = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   bad;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (grant !== e.grant || grant_id !== e.gid || grant_valid !== e.valid) begin
        errors++;
        $display("FAIL grant t=%0t: got grant=%b id=%0d v=%b, want grant=%b id=%0d v=%b",
                 $time, grant, grant_id, grant_valid, e.grant, e.gid, e.valid);
      end
      checks++;
      if (locked !== e.locked) begin
        errors++;
        $display("FAIL locked t=%0t: got %b, want %b", $time, locked, e.locked);
      end
      if (rst_ni && m_lock && e.locked && !req[m_owner]) begin
        $display("protocol violation: owner %0d dropped req while locked", m_owner);
      end
    end
    if (rst_ni) begin
      bad = 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = i + 1; j < N; j++) begin
          if (dut.u_prio.prio_q[i][j] === dut.u_prio.prio_q[j][i]) bad = 1'b1;
        end
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL antisym t=%0t: matrix=%b, want p[i][j] != p[j][i]", $time,
                 dut.u_prio.prio_q);
      end
    end
  end

  initial begin
    int g;
    logic [N-1:0] r;
    logic [N-1:0] l;
    logic         a;
    model_reset();
    for (int k = 0; k < N; k++) weight[k*WW +: WW] = WW'(1);
    #12;

    // Single-flit round robin, weights 1: expect 1,2,4,1,2.
    do_reset(5'b11111);
    for (int k = 0; k < 5; k++) drive(5'b10110, 5'b10110, 1'b1);

    // 4-flit packet on requestor 3, requestor 0 joins at flit 2.
    do_reset('0);
    drive(5'b01000, 5'b00000, 1'b1);
    drive(5'b01001, 5'b00000, 1'b1);
    drive(5'b01001, 5'b00000, 1'b1);
    drive(5'b01001, 5'b01000, 1'b1);
    drive(5'b00001, 5'b00001, 1'b1);

    // Same packet with a 3-cycle ack stall mid-packet.
    do_reset('0);
    drive(5'b01000, 5'b00000, 1'b1);
    drive(5'b01001, 5'b00000, 1'b1);
    for (int k = 0; k < 3; k++) drive(5'b01001, 5'b00000, 1'b0);
    drive(5'b01001, 5'b00000, 1'b1);
    drive(5'b01001, 5'b01000, 1'b1);
    drive(5'b00001, 5'b00001, 1'b1);

    // Weight 3 on requestor 0: expect 0,0,0,1,0,0,0,1.
    do_reset('0);
    weight[0 +: WW] = WW'(3);
    for (int k = 0; k < 8; k++) drive(5'b00011, 5'b00011, 1'b1);

    // All weights zero behave as weight 1.
    do_reset('0);
    weight = '0;
    for (int k = 0; k < 5; k++) drive(5'b10110, 5'b10110, 1'b1);

    // Reset mid-packet while locked on requestor 2.
    do_reset('0);
    for (int k = 0; k < N; k++) weight[k*WW +: WW] = WW'(1);
    drive(5'b00100, 5'b00000, 1'b1);
    drive(5'b00100, 5'b00000, 1'b1);
    do_reset(5'b11111);
    drive(5'b11111, 5'b11111, 1'b1);

    // Randomised legal traffic with varying packet lengths, stalls and weights.
    do_reset('0);
    for (int i = 0; i < N; i++) rem[i] = 0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk);
      #1;
      if (c % 40 == 0) begin
        for (int k = 0; k < N; k++) weight[k*WW +: WW] = WW'($urandom_range(0, 4));
      end
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 4);
        r[i] = (rem[i] > 0);
        l[i] = (rem[i] == 1);
      end
      a    = ($urandom_range(0, 3) != 0);
      req  = r;
      last = l;
      ack  = a;
      model_cycle(g);
      if (g >= 0 && a) rem[g]--;
    end

    @(posedge clk);
    #1;
    req = '0;
    ack = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wormhole_matrix_arbiter.md
Name: wormhole_matrix_arbiter

Overview:
- Parametrised N-input matrix (least-recently-served) arbiter for the NoC switch output stage.
- Packet-aware: once a requestor is granted, the grant locks until its tail flit is accepted downstream.
- Weighted: each requestor may win up to WEIGHT consecutive packets before its priority drops to lowest.
- One instance sits per switch output port, between the input buffers' requests and the crossbar select.

Parameters:
- IN_N, 5, number of requestors (>=2).
- WEIGHT_W, 3, width of each per-requestor weight field.
- ID_W, max(1,clog2(IN_N)), width of the encoded grant index.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- req_i  in  IN_N  per-requestor request; held high for the whole packet.
- last_i  in  IN_N  per-requestor tail-flit flag, valid with req_i.
- ack_i  in  1  downstream accepted the flit of the current grant this cycle.
- weight_i  in  IN_N*WEIGHT_W  packets-per-turn per requestor; field k = bits [k*WEIGHT_W +: WEIGHT_W]; value 0 is treated as 1.
- grant_o  out  IN_N  one-hot grant, or zero.
- grant_id_o  out  ID_W  encoded index of grant_o; 0 when there is no grant.
- grant_valid_o  out  1  |grant_o.
- locked_o  out  1  lock register state (owner mid-packet).

Behaviour:
- Reset values: matrix p[i][j] = 1 for j>i, else 0 (lower index has higher priority); lock_q = 0; owner_q = 0; burst counter cnt_q = 0; cnt_id_q = 0. All outputs 0 while rst_ni is low.
- Unlocked arbitration is combinational, with zero latency.
  - Requestor i wins if req_i[i] is high and no j != i has req_i[j] & p[j][i].
  - At most one grant is issued.
- Locked state: grant_o = onehot(owner_q) & req_i. Matrix arbitration is ignored.
  - If the owner's req drops while locked, grant_o goes to 0 and the lock persists. This is a protocol violation; the bench flags it.
- Lock set: in an unlocked cycle with grant to k and NOT (ack_i & last_i[k]), the next cycle has lock_q = 1 and owner_q = k.
  - A single-flit packet (ack_i & last_i[k] in the grant cycle) never locks.
- Lock release: a locked cycle with ack_i & last_i[owner_q] clears lock_q next cycle.
  - A new arbitration can win in the cycle after release, not the same cycle.
- Packet completion event done = grant_valid_o & ack_i & last_i[gid], where gid = grant_id_o.
- Burst counter:
  - Any grant issued while unlocked to a requestor different from cnt_id_q sets cnt_id_q = that id and cnt_q = 0, before done is evaluated in that cycle.
  - On done: if cnt_q + 1 >= max(weight[gid], 1), update the matrix and set cnt_q = 0. Otherwise cnt_q = cnt_q + 1 and the matrix is unchanged, so gid wins again if it still requests.
  - weight_i is sampled only on done.
- Matrix update for id g: row g is cleared to 0 and column g is set to 1 (excluding the diagonal, which stays 0). The update takes effect on the next edge.
- ack_i with no grant: ignored. ack_i & ~last: no state change other than lock set.
- cnt_q width = WEIGHT_W; it never exceeds weight-1, so no wrap-around occurs.
- Reset mid-packet: everything returns to reset values immediately; the packet is abandoned, and the upstream buffer is reset by the same reset.
- The matrix stays antisymmetric at all times; the bench checks p[i][j] != p[j][i] for i != j.

Decomposition:
- Shared package/include noc_arb_pkg:
  - clog2 function and ID_W derivation.
  - Default WEIGHT_W.
  - onehot-to-index function, reused by other switch arbiters.
- Sub-module matrix_prio_core:
  - Holds the IN_N x IN_N priority matrix with async reset.
  - Inputs: req vector, update strobe, update id.
  - Output: combinational one-hot winner.
- The top level adds the lock/owner register, burst counter and encode logic.

Test Plan:
- Reset, req_i=5'b10110, all weights 1, single-flit packets acked every cycle -> grants 1, 2, 4, 1, 2 on successive cycles; locked_o stays 0.
- req_i[3] with a 4-flit packet (last on flit 4), ack every cycle, req_i[0] raised at flit 2 -> grant_o=5'b01000 for 4 cycles with locked_o=1 during flits 2-4; 5'b00001 in cycle 5.
- Same as above with ack_i low for 3 cycles mid-packet -> grant holds on requestor 3 through the stall; release only after the acked tail.
- weight for requestor 0 = 3, others 1, requestors 0 and 1 continuously sending single-flit packets -> grant sequence 0,0,0,1,0,0,0,1.
- weight_i field = 0 for all -> identical to the weight-1 round-robin case.
- Assert rst_ni low for 1 cycle while locked on requestor 2 -> outputs 0 immediately; after release, req_i=5'b11111 grants requestor 0 first.
